// File: rtl/joy_db15_responder.sv
// -----------------------------------------------------------------------------
// joy_db15_responder
//
// Device-side model of the DB15 dual-joystick shift-register adapter. It
// answers the JOY_LOAD / JOY_CLK strobes from a joy_db15 host reader and
// returns the button states serially, like a chain of parallel-load shift
// registers. It serves as a loopback partner for joy_db15 and as a stand-in
// adapter on the USER port.
//
// Ports
//   clk           system clock, at least 8x the JOY_CLK toggle rate
//   RESET_L       asynchronous reset, active low; release is synchronous to clk
//   joystick1     player 1 buttons, 1 = pressed (bit0=R,1=L,2=D,3=U,4+=fire)
//   joystick2     player 2 buttons, same encoding
//   joy_load_in   host JOY_LOAD (async); low = parallel load
//   joy_clk_in    host JOY_CLK (async); a rising edge shifts one bit
//   joy_data_out  serial data to the host, active low (0 = pressed)
//   frame_done    one-cycle pulse when the last frame bit has been shifted out
//   shift_cnt     shifts taken since the last load, saturates at 2*JOY_BITS
//   overrun       sticky: a shift arrived after the frame was exhausted
// -----------------------------------------------------------------------------
module joy_db15_responder #(
   parameter int JOY_BITS    = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                RESET_L,
   input  logic [JOY_BITS-1:0] joystick1,
   input  logic [JOY_BITS-1:0] joystick2,
   input  logic                joy_load_in,
   input  logic                joy_clk_in,
   output logic                joy_data_out,
   output logic                frame_done,
   output logic [4:0]          shift_cnt,
   output logic                overrun
);

   localparam int         FRAME_BITS = 2 * JOY_BITS;
   localparam logic [4:0] FRAME_LEN  = 5'(FRAME_BITS);

   typedef enum logic {
      ST_LOAD,
      ST_SHIFT
   } mode_t;

   // Shift counter that stops at the frame length.
   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v < FRAME_LEN) ? v + 5'd1 : v;
   endfunction

   // ---- p0: strobe synchronisers ---------------------------------------------
   // All flops reset to 1 so a strobe idling high out of reset makes no edge.
   logic [SYNC_STAGES-1:0] load_sync_p0;
   logic [SYNC_STAGES-1:0] clk_sync_p0;
   logic                   clk_s_p1;

   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         load_sync_p0 <= '1;
         clk_sync_p0  <= '1;
         clk_s_p1     <= 1'b1;
      end else begin
         load_sync_p0 <= {load_sync_p0[SYNC_STAGES-2:0], joy_load_in};
         clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], joy_clk_in};
         clk_s_p1     <= clk_sync_p0[SYNC_STAGES-1];
      end
   end

   logic  load_s;
   logic  clk_s;
   logic  clk_edge;
   mode_t mode;

   assign load_s   = load_sync_p0[SYNC_STAGES-1];
   assign clk_s    = clk_sync_p0[SYNC_STAGES-1];
   assign clk_edge = clk_s & ~clk_s_p1;
   assign mode     = load_s ? ST_SHIFT : ST_LOAD;

   // ---- p2: shift register, counter and status -------------------------------
   logic [FRAME_BITS-1:0] sr_p2, sr_nxt;
   logic [4:0]            cnt_p2, cnt_nxt;
   logic                  ovr_p2, ovr_nxt;
   logic                  fd_p2, fd_nxt;

   always_comb begin
      sr_nxt  = sr_p2;
      cnt_nxt = cnt_p2;
      ovr_nxt = ovr_p2;
      fd_nxt  = 1'b0;
      case (mode)
         // Transparent reload every cycle; a clk edge in the same cycle as the
         // load is simply dropped because this branch never looks at it.
         ST_LOAD: begin
            sr_nxt  = ~{joystick2, joystick1};
            cnt_nxt = '0;
            ovr_nxt = 1'b0;
         end
         ST_SHIFT: begin
            if (clk_edge) begin
               sr_nxt = {1'b1, sr_p2[FRAME_BITS-1:1]};
               if (cnt_p2 == FRAME_LEN) begin
                  ovr_nxt = 1'b1;
               end else begin
                  cnt_nxt = sat_inc(cnt_p2);
                  fd_nxt  = (sat_inc(cnt_p2) == FRAME_LEN);
               end
            end
         end
         default: begin
            sr_nxt = sr_p2;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         sr_p2  <= '1;
         cnt_p2 <= '0;
         ovr_p2 <= 1'b0;
         fd_p2  <= 1'b0;
      end else begin
         sr_p2  <= sr_nxt;
         cnt_p2 <= cnt_nxt;
         ovr_p2 <= ovr_nxt;
         fd_p2  <= fd_nxt;
      end
   end

   assign joy_data_out = sr_p2[0];
   assign frame_done   = fd_p2;
   assign shift_cnt    = cnt_p2;
   assign overrun      = ovr_p2;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Bench for joy_db15_responder: table of load/shift vectors plus hand-written
// sequences for reset, full frame, overrun, snapshot hold, load-vs-shift
// collision and asynchronous reset mid-frame.
module tb_joy_db15_responder;

   logic        clk;
   logic        RESET_L;
   logic [11:0] joystick1;
   logic [11:0] joystick2;
   logic        joy_load_in;
   logic        joy_clk_in;
   logic        joy_data_out;
   logic        frame_done;
   logic [4:0]  shift_cnt;
   logic        overrun;

   int total = 0;
   int bad   = 0;
   int fd_cnt = 0;

   joy_db15_responder #(.JOY_BITS(12), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .RESET_L      (RESET_L),
      .joystick1    (joystick1),
      .joystick2    (joystick2),
      .joy_load_in  (joy_load_in),
      .joy_clk_in   (joy_clk_in),
      .joy_data_out (joy_data_out),
      .frame_done   (frame_done),
      .shift_cnt    (shift_cnt),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count frame_done pulses; each pulse spans exactly one negedge.
   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
   end

   typedef struct {
      logic [11:0] j1;
      logic [11:0] j2;
      int          nshift;
      logic        exp_data;
      logic [4:0]  exp_cnt;
      logic        exp_ovr;
      int          exp_fd;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // JOY_CLK idles high: drop for 4 cycles, rise and hold 4 cycles; the shift
   // lands 3 cycles after the rise.
   task automatic pulse_clk();
      joy_clk_in = 1'b0;
      wait_cyc(4);
      joy_clk_in = 1'b1;
      wait_cyc(4);
   endtask

   task automatic pulse_load();
      joy_load_in = 1'b0;
      wait_cyc(4);
      joy_load_in = 1'b1;
      wait_cyc(4);
   endtask

   initial begin
      int fd0;
      logic exp_bit;

      // Frame bit n = ~{j2,j1}[n], or 1 once n >= 24.
      vecs[0] = '{12'h001, 12'h800, 0,  1'b0, 5'd0,  1'b0, 0};
      vecs[1] = '{12'h001, 12'h800, 1,  1'b1, 5'd1,  1'b0, 0};
      vecs[2] = '{12'h0A5, 12'h000, 2,  1'b0, 5'd2,  1'b0, 0};
      vecs[3] = '{12'h000, 12'h004, 14, 1'b0, 5'd14, 1'b0, 0};
      vecs[4] = '{12'hFFF, 12'hFFF, 23, 1'b0, 5'd23, 1'b0, 0};
      vecs[5] = '{12'h000, 12'h000, 24, 1'b1, 5'd24, 1'b0, 1};
      vecs[6] = '{12'h000, 12'h000, 25, 1'b1, 5'd24, 1'b1, 1};
      vecs[7] = '{12'h800, 12'h000, 11, 1'b0, 5'd11, 1'b0, 0};

      RESET_L     = 1'b0;
      joy_load_in = 1'b1;
      joy_clk_in  = 1'b1;
      joystick1   = '0;
      joystick2   = '0;
      wait_cyc(3);
      check("reset_state", {joy_data_out, shift_cnt, frame_done, overrun}, 8'b1_00000_0_0);

      // Test 1: idle after release with both strobes high.
      RESET_L = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wait_cyc(1);
         check("idle_after_reset", {joy_data_out, shift_cnt, frame_done, overrun}, 8'b1_00000_0_0);
      end

      // Table vectors.
      for (int v = 0; v < 8; v++) begin
         joystick1 = vecs[v].j1;
         joystick2 = vecs[v].j2;
         pulse_load();
         fd0 = fd_cnt;
         for (int s = 0; s < vecs[v].nshift; s++) pulse_clk();
         check($sformatf("vec%0d_data", v), 32'(joy_data_out), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d_cnt", v), 32'(shift_cnt), 32'(vecs[v].exp_cnt));
         check($sformatf("vec%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
         check($sformatf("vec%0d_fd", v), 32'(fd_cnt - fd0), 32'(vecs[v].exp_fd));
      end

      // Test 2: full frame stream.
      joystick1 = 12'h001;
      joystick2 = 12'h800;
      pulse_load();
      check("t2_fd_after_load", 32'(frame_done), 32'd0);
      fd0 = fd_cnt;
      for (int k = 0; k < 24; k++) begin
         exp_bit = (k == 0 || k == 23) ? 1'b0 : 1'b1;
         check($sformatf("t2_bit%0d", k), 32'(joy_data_out), 32'(exp_bit));
         pulse_clk();
      end
      check("t2_fd_once", 32'(fd_cnt - fd0), 32'd1);
      check("t2_end_data", 32'(joy_data_out), 32'd1);
      check("t2_end_cnt", 32'(shift_cnt), 32'd24);
      check("t2_no_ovr", 32'(overrun), 32'd0);

      // Test 3: overrun after exhaustion, cleared by the next load.
      for (int k = 0; k < 3; k++) pulse_clk();
      check("t3_data", 32'(joy_data_out), 32'd1);
      check("t3_cnt", 32'(shift_cnt), 32'd24);
      check("t3_ovr", 32'(overrun), 32'd1);
      check("t3_fd_none", 32'(fd_cnt - fd0), 32'd1);
      pulse_load();
      check("t3_ovr_clr", 32'(overrun), 32'd0);
      check("t3_cnt_clr", 32'(shift_cnt), 32'd0);
      check("t3_fd_none_load", 32'(fd_cnt - fd0), 32'd1);

      // Test 4: snapshot held while shifting; reload picks up new inputs.
      joystick1 = 12'h000;
      joystick2 = 12'h000;
      pulse_load();
      for (int k = 0; k < 5; k++) pulse_clk();
      joystick1 = 12'hFFF;
      for (int k = 5; k < 12; k++) begin
         check($sformatf("t4_old_bit%0d", k), 32'(joy_data_out), 32'd1);
         pulse_clk();
      end
      joy_load_in = 1'b0;
      wait_cyc(4);
      check("t4_load_head", 32'(joy_data_out), 32'd0);
      joystick1 = 12'hFFE;
      wait_cyc(4);
      check("t4_transparent", 32'(joy_data_out), 32'd1);
      joystick1 = 12'hFFF;
      wait_cyc(4);
      joy_load_in = 1'b1;
      wait_cyc(4);
      check("t4_new_bit0", 32'(joy_data_out), 32'd0);
      pulse_clk();
      check("t4_new_bit1", 32'(joy_data_out), 32'd0);
      check("t4_cnt", 32'(shift_cnt), 32'd1);

      // Test 5: load falls together with a clk rise mid-frame.
      joystick1 = 12'h001;
      joystick2 = 12'h800;
      pulse_load();
      for (int k = 0; k < 10; k++) pulse_clk();
      check("t5_cnt10", 32'(shift_cnt), 32'd10);
      fd0 = fd_cnt;
      joy_clk_in = 1'b0;
      wait_cyc(4);
      joy_clk_in  = 1'b1;
      joy_load_in = 1'b0;
      wait_cyc(4);
      check("t5_cnt", 32'(shift_cnt), 32'd0);
      check("t5_head", 32'(joy_data_out), 32'd0);
      check("t5_no_fd", 32'(fd_cnt - fd0), 32'd0);
      joy_load_in = 1'b1;
      wait_cyc(4);
      check("t5_hold_cnt", 32'(shift_cnt), 32'd0);

      // Test 6: asynchronous reset mid-frame.
      joystick1 = 12'hFFF;
      joystick2 = 12'hFFF;
      pulse_load();
      for (int k = 0; k < 7; k++) pulse_clk();
      check("t6_pre", {joy_data_out, shift_cnt, frame_done, overrun}, 8'b0_00111_0_0);
      #2;
      RESET_L = 1'b0;
      #1;
      check("t6_async", {joy_data_out, shift_cnt, frame_done, overrun}, 8'b1_00000_0_0);
      wait_cyc(2);
      RESET_L = 1'b1;
      wait_cyc(5);
      check("t6_after", {joy_data_out, shift_cnt, frame_done, overrun}, 8'b1_00000_0_0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
